updown_classifier: RTL and testbench

- Registered direction classifier for the elevator controller.
- Takes seven passenger request words. Each word packs a source floor and a destination floor.
- Produces one-hot-per-passenger "going up" and "going down" masks, plus a population count of each.
- Sits between the request-capture stage and the elevator scheduling FSM.

---
 rtl/updown_pkg.sv | 26 ++
 rtl/passenger_dir.sv | 21 ++
 rtl/updown_classifier.sv | 71 +++++++
 tb/tb_updown_classifier.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types and helpers for the elevator up/down direction classifier.
package updown_pkg;

  localparam int unsigned FLOOR_W  = 3;
  localparam int unsigned NUM_PASS = 7;
  localparam int unsigned PASS_W   = 2 * FLOOR_W;
  localparam int unsigned CNT_W    = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef struct packed {
    floor_t src;
    floor_t dst;
  } pass_req_t;

  // Population count of a passenger mask; NUM_PASS = 7 always fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PASS-1:0] mask);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_PASS; i++) begin
      cnt = cnt + CNT_W'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/passenger_dir.sv
// Combinational direction decode for one passenger request word.
module passenger_dir
  import updown_pkg::*;
(
  input  pass_req_t i_req,
  output logic      o_up,
  output logic      o_down
);

  // Equal floors mean an idle or empty slot, so neither flag is raised.
  always_comb begin
    o_up   = 1'b0;
    o_down = 1'b0;
    if (i_req.dst > i_req.src) begin
      o_up = 1'b1;
    end else if (i_req.dst < i_req.src) begin
      o_down = 1'b1;
    end
  end

endmodule

// File: rtl/updown_classifier.sv
// Registered up/down classifier: per-passenger direction masks plus their popcounts.
module updown_classifier
  import updown_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PASS_W-1:0]   passenger_1,
  input  logic [PASS_W-1:0]   passenger_2,
  input  logic [PASS_W-1:0]   passenger_3,
  input  logic [PASS_W-1:0]   passenger_4,
  input  logic [PASS_W-1:0]   passenger_5,
  input  logic [PASS_W-1:0]   passenger_6,
  input  logic [PASS_W-1:0]   passenger_7,
  output logic [NUM_PASS-1:0] up_passenger,
  output logic [NUM_PASS-1:0] down_passenger,
  output logic [CNT_W-1:0]    up_count,
  output logic [CNT_W-1:0]    down_count
);

  logic [PASS_W-1:0]   w_words [NUM_PASS];
  logic [NUM_PASS-1:0] w_up;
  logic [NUM_PASS-1:0] w_down;
  logic [CNT_W-1:0]    w_up_cnt;
  logic [CNT_W-1:0]    w_down_cnt;

  logic [NUM_PASS-1:0] r_up;
  logic [NUM_PASS-1:0] r_down;
  logic [CNT_W-1:0]    r_up_cnt;
  logic [CNT_W-1:0]    r_down_cnt;

  // passenger_1 lands on bit 0, passenger_7 on bit 6.
  assign w_words[0] = passenger_1;
  assign w_words[1] = passenger_2;
  assign w_words[2] = passenger_3;
  assign w_words[3] = passenger_4;
  assign w_words[4] = passenger_5;
  assign w_words[5] = passenger_6;
  assign w_words[6] = passenger_7;

  for (genvar g = 0; g < NUM_PASS; g++) begin : g_dir
    passenger_dir u_dir (
      .i_req  (pass_req_t'(w_words[g])),
      .o_up   (w_up[g]),
      .o_down (w_down[g])
    );
  end

  assign w_up_cnt   = popcount(w_up);
  assign w_down_cnt = popcount(w_down);

  // Masks and counts share one register stage so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up       <= '0;
      r_down     <= '0;
      r_up_cnt   <= '0;
      r_down_cnt <= '0;
    end else begin
      r_up       <= w_up;
      r_down     <= w_down;
      r_up_cnt   <= w_up_cnt;
      r_down_cnt <= w_down_cnt;
    end
  end

  assign up_passenger   = r_up;
  assign down_passenger = r_down;
  assign up_count       = r_up_cnt;
  assign down_count     = r_down_cnt;

endmodule

// File: tb/tb_updown_classifier.sv
// Scoreboard bench for updown_classifier: driver queues expectations, monitor checks after each edge.
module tb_updown_classifier;

  typedef logic [5:0] vec_t [7];

  typedef struct {
    logic [6:0] up;
    logic [6:0] dn;
    logic [2:0] uc;
    logic [2:0] dc;
    int         tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] p1, p2, p3, p4, p5, p6, p7;
  logic [6:0] up_passenger, down_passenger;
  logic [2:0] up_count, down_count;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  updown_classifier dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .passenger_1    (p1),
    .passenger_2    (p2),
    .passenger_3    (p3),
    .passenger_4    (p4),
    .passenger_5    (p5),
    .passenger_6    (p6),
    .passenger_7    (p7),
    .up_passenger   (up_passenger),
    .down_passenger (down_passenger),
    .up_count       (up_count),
    .down_count     (down_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, tag, act, req);
    end
  endtask

  // Independent reference: field-wise compare of each word.
  function automatic exp_t model(input vec_t w, input int tag);
    exp_t e;
    e.up = '0; e.dn = '0; e.uc = '0; e.dc = '0; e.tag = tag;
    for (int i = 0; i < 7; i++) begin
      logic [5:0] wd;
      int s, d;
      wd = w[i];
      s = int'(wd[5:3]);
      d = int'(wd[2:0]);
      if (d > s) begin e.up[i] = 1'b1; e.uc = e.uc + 3'd1; end
      if (d < s) begin e.dn[i] = 1'b1; e.dc = e.dc + 3'd1; end
    end
    return e;
  endfunction

  task automatic drive(input vec_t w);
    p1 = w[0]; p2 = w[1]; p3 = w[2]; p4 = w[3];
    p5 = w[4]; p6 = w[5]; p7 = w[6];
  endtask

  // Apply a vector at the falling edge and queue what must appear after the next rising edge.
  task automatic apply(input vec_t w, input logic [6:0] up, input logic [6:0] dn,
                       input logic [2:0] uc, input logic [2:0] dc, input int tag);
    exp_t e;
    @(negedge clk);
    drive(w);
    e.up = up; e.dn = dn; e.uc = uc; e.dc = dc; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", tag, q.size(), 0);
  endtask

  task automatic fill(input logic [5:0] v, output vec_t w);
    for (int i = 0; i < 7; i++) w[i] = v;
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("up_passenger",   e.tag, int'(up_passenger),   int'(e.up));
        check("down_passenger", e.tag, int'(down_passenger), int'(e.dn));
        check("up_count",       e.tag, int'(up_count),       int'(e.uc));
        check("down_count",     e.tag, int'(down_count),     int'(e.dc));
        check("mask_overlap",   e.tag, int'(up_passenger & down_passenger), 0);
        check("up_cnt_pop",     e.tag, int'(up_count),   $countones(up_passenger));
        check("dn_cnt_pop",     e.tag, int'(down_count), $countones(down_passenger));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w;
    exp_t e;

    // Reset with non-idle inputs: outputs must be zero without any clock edge.
    rst_n = 1'b0;
    fill(6'b000111, w);
    drive(w);
    #2;
    check("rst_up",  0, int'(up_passenger), 0);
    check("rst_dn",  0, int'(down_passenger), 0);
    check("rst_uc",  0, int'(up_count), 0);
    check("rst_dc",  0, int'(down_count), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_up", 0, int'(up_passenger), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed load.
    w[0] = 6'b000011; w[1] = 6'b110001; w[2] = 6'b000101; w[3] = 6'b000010;
    w[4] = 6'b000100; w[5] = 6'b111000; w[6] = 6'b000000;
    apply(w, 7'd29, 7'd34, 3'd4, 3'd2, 1);

    // All idle, various equal-floor encodings.
    w[0] = 6'b000000; w[1] = 6'b011011; w[2] = 6'b111111; w[3] = 6'b001001;
    w[4] = 6'b010010; w[5] = 6'b100100; w[6] = 6'b101101;
    apply(w, 7'h00, 7'h00, 3'd0, 3'd0, 2);

    fill(6'b000111, w);
    apply(w, 7'h7F, 7'h00, 3'd7, 3'd0, 3);
    fill(6'b111000, w);
    apply(w, 7'h00, 7'h7F, 3'd0, 3'd7, 4);

    // Only the top slot active: checks passenger_7 -> bit 6.
    fill(6'b000000, w);
    w[6] = 6'b001010;
    apply(w, 7'h40, 7'h00, 3'd1, 3'd0, 5);
    wait_drain(5);

    // Adjacent floors, with a pre-edge check that the old result still holds.
    fill(6'b000000, w);
    apply(w, 7'h00, 7'h00, 3'd0, 3'd0, 6);
    w[0] = 6'b011100;
    apply(w, 7'h01, 7'h00, 3'd1, 3'd0, 7);
    #1;
    check("early_up_3to4", 7, int'(up_passenger), 0);
    w[0] = 6'b100011;
    apply(w, 7'h00, 7'h01, 3'd0, 3'd1, 8);
    #1;
    check("early_up_4to3", 8, int'(up_passenger), 1);
    check("early_dn_4to3", 8, int'(down_passenger), 0);
    wait_drain(8);

    // Mid-run asynchronous reset.
    fill(6'b000111, w);
    apply(w, 7'h7F, 7'h00, 3'd7, 3'd0, 9);
    wait_drain(9);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_up", 10, int'(up_passenger), 0);
    check("midrst_uc", 10, int'(up_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(w, 7'h7F, 7'h00, 3'd7, 3'd0, 11);

    // Random vectors against the reference model.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 7; i++) w[i] = 6'($urandom_range(0, 63));
      e = model(w, 100 + n);
      apply(w, e.up, e.dn, e.uc, e.dc, e.tag);
    end
    wait_drain(2000);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
